// File: rtl/mips_muldiv_pkg.sv
// Shared encodings and sizing helpers for the MIPS multiply/divide unit.
// The counter width depends on the instance WIDTH, so it is a function here.
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldivOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10
    } muldivState_e;

    function automatic int unsigned cntWidth(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Core-side bundle of the multiply/divide unit: launch, abort, MTHI/MTLO and HI/LO readout.
interface mips_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one step per cycle.
// The 2*WIDTH accumulator holds {upper, multiplier} or {remainder, quotient}.
module muldiv_iter_core
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               isDiv,
    input  logic [WIDTH-1:0]   aMag,
    input  logic [WIDTH-1:0]   bMag,
    output logic               lastStep,
    output logic [2*WIDTH-1:0] acc
);
    localparam int unsigned CntW = cntWidth(WIDTH);

    logic [2*WIDTH-1:0] accQ, accD;
    logic [WIDTH-1:0]   bQ, bD;
    logic [CntW-1:0]    cntQ, cntD;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH-1:0]   divDiff;
    logic               divFits;

    always_comb begin
        mulSum   = {1'b0, accQ[2*WIDTH-1:WIDTH]} + {1'b0, (accQ[0] ? bQ : {WIDTH{1'b0}})};
        // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
        divShift = accQ[2*WIDTH-1:WIDTH-1];
        divFits  = divShift >= {1'b0, bQ};
        divDiff  = divShift[WIDTH-1:0] - bQ;

        accD = accQ;
        bD   = bQ;
        cntD = cntQ;
        if (load) begin
            accD = {{WIDTH{1'b0}}, aMag};
            bD   = bMag;
            cntD = CntW'(WIDTH - 1);
        end else if (step) begin
            if (isDiv) begin
                accD = {(divFits ? divDiff : divShift[WIDTH-1:0]), accQ[WIDTH-2:0], divFits};
            end else begin
                accD = {mulSum, accQ[WIDTH-1:1]};
            end
            if (cntQ != '0) begin
                cntD = cntQ - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accQ <= '0;
            bQ   <= '0;
            cntQ <= '0;
        end else begin
            accQ <= accD;
            bQ   <= bD;
            cntQ <= cntD;
        end
    end

    assign lastStep = (cntQ == '0);
    assign acc      = accQ;
endmodule

// File: rtl/mips_muldiv_unit.sv
// HI/LO multiply/divide unit: FSM, operand sign handling, result fix-up, abort and MTHI/MTLO.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    mips_muldiv_if.slave  bus
);
    muldivState_e       stateQ, stateD;
    logic [1:0]         opQ;
    logic               signAQ, signBQ, bZeroQ;
    logic [WIDTH-1:0]   hiQ, hiD, loQ, loD;
    logic               accept, launchSigned, opSigned, opDiv, lastStep;
    logic               doneC, dbzC;
    logic [WIDTH-1:0]   aMag, bMag, quo, rem, fixHi, fixLo;
    logic [2*WIDTH-1:0] acc, prod;

    assign accept       = (stateQ == IDLE) && bus.start && !bus.flush;
    assign launchSigned = !bus.op[0];
    assign aMag = (launchSigned && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    assign bMag = (launchSigned && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
    assign opSigned = !opQ[0];
    assign opDiv    = opQ[1];

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (stateQ == ITER),
        .isDiv    (opDiv),
        .aMag     (aMag),
        .bMag     (bMag),
        .lastStep (lastStep),
        .acc      (acc)
    );

    // Most-negative / -1 needs no special case: the negated quotient wraps back to itself.
    always_comb begin
        prod  = (opSigned && (signAQ ^ signBQ)) ? -acc : acc;
        quo   = (opSigned && (signAQ ^ signBQ)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem   = (opSigned && signAQ) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fixHi = opDiv ? rem : prod[2*WIDTH-1:WIDTH];
        fixLo = opDiv ? quo : prod[WIDTH-1:0];
    end

    always_comb begin
        stateD = stateQ;
        hiD    = hiQ;
        loD    = loQ;
        doneC  = 1'b0;
        dbzC   = 1'b0;
        unique case (stateQ)
            IDLE: begin
                if (accept) begin
                    stateD = ITER;
                end else begin
                    if (bus.hi_we) hiD = bus.wdata;
                    if (bus.lo_we) loD = bus.wdata;
                end
            end
            ITER: begin
                if (bus.flush) begin
                    stateD = IDLE;
                end else if (lastStep) begin
                    stateD = FIX;
                end
            end
            FIX: begin
                stateD = IDLE;
                if (!bus.flush) begin
                    hiD   = fixHi;
                    loD   = fixLo;
                    doneC = 1'b1;
                    dbzC  = opDiv && bZeroQ;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
            opQ    <= '0;
            signAQ <= 1'b0;
            signBQ <= 1'b0;
            bZeroQ <= 1'b0;
            hiQ    <= '0;
            loQ    <= '0;
        end else begin
            stateQ <= stateD;
            hiQ    <= hiD;
            loQ    <= loD;
            if (accept) begin
                opQ    <= bus.op;
                signAQ <= bus.rs_data[WIDTH-1];
                signBQ <= bus.rt_data[WIDTH-1];
                bZeroQ <= (bus.rt_data == '0);
            end
        end
    end

    assign bus.busy        = (stateQ != IDLE);
    assign bus.done        = doneC;
    assign bus.div_by_zero = dbzC;
    assign bus.hi          = hiQ;
    assign bus.lo          = loQ;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: expected HI/LO pushed at launch, popped at done.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    mips_muldiv_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e = '0;
        case (op)
            OP_MULT:  begin p = 64'(sa * sb); e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; end
            OP_MULTU: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.hi = p[2*W-1:W];
                e.lo = p[W-1:0];
            end
            OP_DIVU: begin
                if (b == '0) begin e.lo = '1; e.hi = a; e.dbz = 1'b1; end
                else begin e.lo = a / b; e.hi = a % b; end
            end
            default: begin
                if (b == '0) begin
                    e.dbz = 1'b1;
                    e.hi  = a;
                    e.lo  = (sa < 0) ? W'(1) : '1;
                end else if (a == 32'h8000_0000 && b == '1) begin
                    e.lo = a;
                    e.hi = '0;
                end else begin
                    e.lo = W'(sa / sb);
                    e.hi = W'(sa % sb);
                end
            end
        endcase
        return e;
    endfunction

    // Launch one op, optionally poke a second start while busy, and watch a fixed window.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input exp_t e, input bit intrude);
        int   busyCycles = 0;
        int   doneCount = 0;
        bit   pending = 0;
        exp_t x;
        sbQ.push_back(e);
        @(negedge clk);
        bus.op = op; bus.rs_data = a; bus.rt_data = b; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (pending) begin
                check({tag, " hi"}, bus.hi, x.hi);
                check({tag, " lo"}, bus.lo, x.lo);
                check({tag, " busy after"}, bus.busy, 1'b0);
                pending = 0;
            end
            if (bus.busy) busyCycles++;
            if (bus.done) begin
                doneCount++;
                if (doneCount == 1) begin
                    x = sbQ.pop_front();
                    check({tag, " div_by_zero"}, bus.div_by_zero, x.dbz);
                    pending = 1;
                end
            end
            if (intrude && i == 5) begin
                bus.op = OP_DIVU; bus.rs_data = 9; bus.rt_data = 0; bus.start = 1'b1;
            end
            if (intrude && i == 7) bus.start = 1'b0;
        end
        if (doneCount == 0) void'(sbQ.pop_front());
        check({tag, " done count"}, doneCount, 1);
        check({tag, " busy cycles"}, busyCycles, W + 1);
    endtask

    initial begin : stim
        int busyCycles;
        int doneCount;
        logic [W-1:0] ra, rb;
        bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0; bus.flush = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;

        #1;
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset dbz", bus.div_by_zero, 1'b0);
        check("reset hi", bus.hi, 0);
        check("reset lo", bus.lo, 0);
        #11 reset = 1'b1;

        runOp("MULT -3x5", OP_MULT, 32'hFFFF_FFFD, 5, '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0}, 0);
        runOp("MULTU max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0}, 0);
        runOp("DIVU 100/7", OP_DIVU, 100, 7, '{32'd2, 32'd14, 1'b0}, 0);
        runOp("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}, 0);
        runOp("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0, 32'h8000_0000, 1'b0}, 0);
        runOp("DIVU 5/0", OP_DIVU, 5, 0, '{32'd5, 32'hFFFF_FFFF, 1'b1}, 0);

        // MTHI, then an op aborted on its tenth busy cycle.
        @(negedge clk);
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk);
        #1 bus.hi_we = 1'b0;
        @(negedge clk);
        check("mthi hi", bus.hi, 32'h1234);
        bus.op = OP_MULTU; bus.rs_data = 3; bus.rt_data = 4; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busyCycles = 0;
        doneCount  = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.busy) busyCycles++;
            if (bus.done) doneCount++;
        end
        check("flush busy before", busyCycles, 10);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush busy", bus.busy, 1'b0);
        check("flush hi", bus.hi, 32'h1234);
        check("flush lo", bus.lo, 32'hFFFF_FFFF);
        repeat (40) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        check("flush no done", doneCount, 0);

        runOp("start during busy", OP_MULTU, 2, 3, '{32'd0, 32'd6, 1'b0}, 1);

        ra = $urandom; rb = $urandom;
        runOp("MULT rand", OP_MULT, ra, rb, model(OP_MULT, ra, rb), 0);
        ra = $urandom; rb = $urandom_range(1, 32'hFFFF);
        if ($urandom_range(0, 1) == 1) rb = -rb;
        runOp("DIV rand", OP_DIV, ra, rb, model(OP_DIV, ra, rb), 0);

        // Asynchronous reset between edges in the middle of an operation.
        @(negedge clk);
        bus.op = OP_MULT; bus.rs_data = 32'h1111; bus.rt_data = 32'h2222; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async rst busy", bus.busy, 1'b0);
        check("async rst hi", bus.hi, 0);
        check("async rst lo", bus.lo, 0);
        @(negedge clk);
        reset = 1'b1;

        bus.lo_we = 1'b1; bus.wdata = 32'hDEAD;
        runOp("start+mtlo", OP_MULTU, 6, 7, '{32'd0, 32'd42, 1'b0}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. Adds MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO to the 5-stage pipelined MIPS core.
- Sits beside the ALU in EX. The core launches an operation from ID/EX and reads HI/LO for MFHI/MFLO.
- The hazard unit stalls IF/ID/EX while busy=1 and an HI/LO-dependent instruction is in ID.
- Generalises the single-cycle ALU to a parametrised, multi-cycle, abortable datapath.

Parameters:
- WIDTH, 32, operand width. Must be even and at least 4. HI and LO are WIDTH bits each.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch request, sampled only when busy=0
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  input  WIDTH  multiplicand or dividend (forwarded value)
- rt_data  input  WIDTH  multiplier or divisor (forwarded value)
- flush  input  1  abort the in-flight operation (branch or jump squash)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated by an operation
- div_by_zero  output  1  pulses together with done when a DIV or DIVU had divisor 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; all internal registers cleared.
- A reset during an operation discards it immediately.
- States: IDLE, ITER, FIX.
- IDLE, start=1: latch op, the operand magnitudes and both sign bits. Go to ITER with count=WIDTH-1 and busy=1 from the next cycle.
  - Signed ops (MULT, DIV) take the two's-complement magnitude of each operand. Unsigned ops use the raw values.
- ITER, multiply: one shift-add step per cycle into a 2*WIDTH accumulator.
- ITER, divide: one restoring step per cycle (shift, trial subtract, set quotient bit).
- ITER exit: when count=0 go to FIX; otherwise decrement count.
- FIX (one cycle):
  - Signed multiply: negate the product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write hi=upper half / remainder and lo=lower half / quotient. Assert done (and div_by_zero if applicable).
  - Go to IDLE. busy=0 from the next cycle.
- Latency: busy is high for exactly WIDTH+1 cycles. HI/LO are visible the cycle after FIX, coincident with done falling.
- start while busy=1 is ignored; there is no queueing.
- flush=1 in ITER or FIX: abort. HI/LO keep their pre-operation values, done and div_by_zero stay 0, state=IDLE and busy=0 next cycle.
- flush has priority over FIX completion.
- flush in IDLE has no effect. flush and start together in IDLE: flush wins and nothing is launched.
- Divide by zero: no special datapath. The restoring result gives LO=all ones and HI=dividend magnitude, then FIX applies the normal sign rules. div_by_zero pulses.
- Signed overflow (most negative value / -1): LO=most negative value, HI=0. No flag.
- MTHI/MTLO: hi_we and lo_we write on the next edge, only when busy=0 and not in the same cycle as an accepted start.
  - If start is accepted in the same cycle, the writes are dropped.
  - Writes while busy=1 are dropped. Preventing them is the hazard unit's contract.
- hi and lo are pure register outputs with no combinational path from the inputs.

Decomposition:
- Shared package mips_muldiv_pkg: the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum (IDLE, ITER, FIX), and the width of the counter, $clog2(WIDTH).
- One natural sub-module, muldiv_iter_core. It holds the accumulator/remainder, the counter and the per-step mul/div logic.
- The top level keeps the FSM, sign handling, HI/LO, flush and the MT writes.

Test Plan:
- WIDTH=32, MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high 33 cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIVU 100/7 -> lo=14, hi=2.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero and done pulse in the same cycle.
- MTHI 0x1234 then MULTU 3x4 with flush on busy cycle 10 -> busy=0 next cycle, hi=0x1234, no done. A start during busy is ignored and no second done occurs.
- Assert reset=0 asynchronously mid-ITER (between clock edges) -> busy, hi and lo are 0 immediately. start plus lo_we in the same IDLE cycle -> the lo_we write is dropped and the op result lands in lo.
